// File: rtl/bus_resp_pkg.sv
// ---------------------------------------------------------------------------
// bus_resp_pkg
//   Shared definitions for the shared-bus slave responder and its controller:
//   response codes, read/write encoding, responder state encoding and the
//   width of the wait-state counter.
// ---------------------------------------------------------------------------
package bus_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2,
        ST_RTY1,
        ST_RTY2
    } rsp_state_e;

    // ready is low only in the first cycle of a response and while waiting.
    function automatic logic state_ready(rsp_state_e st);
        return !(st == ST_WAIT || st == ST_ERR1 || st == ST_RTY1);
    endfunction

endpackage

// File: rtl/slave_wait_counter.sv
// ---------------------------------------------------------------------------
// slave_wait_counter
//   Loadable down-counter that paces wait states of a legal access.
//   Ports:
//     clk, rst   clock, synchronous active-high reset (clears to 0)
//     load       load the counter with value (wins over dec)
//     value      load value
//     dec        decrement by one; saturates at 0
//     zero       counter currently equals 0
// ---------------------------------------------------------------------------
module slave_wait_counter
    import bus_resp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] value,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_slave_responder.sv
// ---------------------------------------------------------------------------
// bus_slave_responder
//   Slave-side responder for the two-master shared bus. Decodes selected
//   accesses to a local word memory, inserts WAIT_CYCLES wait states and
//   produces two-cycle ERROR (out of range) or RETRY/SPLIT (hold) responses.
//   Optional feature: define SLAVE_SPLIT_EN to answer held accesses with
//   SPLIT and pulse split once the slave becomes available again; without it
//   held accesses get RETRY and split is tied low.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     sel           access request, sampled in IDLE/DONE only
//     read_write    1 = write, 0 = read (sampled with sel)
//     addr, wdata   word address and write data (sampled with sel)
//     hold          slave temporarily unavailable
//     rdata         read data, valid in the DONE cycle of a read
//     ready         transfer complete / slave idle
//     response      OKAY / ERROR / RETRY / SPLIT
//     split         one-cycle pulse: split transfer may be re-arbitrated
// ---------------------------------------------------------------------------
module bus_slave_responder
    import bus_resp_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          read_write,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          hold,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic [1:0]    response,
    output logic          split
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);
`ifdef SLAVE_SPLIT_EN
    localparam resp_e RTY_RESP = RESP_SPLIT;
`else
    localparam resp_e RTY_RESP = RESP_RETRY;
`endif

    logic [DW-1:0] mem_q [DEPTH];

    rsp_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic          rw_q, rw_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic [1:0]    response_q, response_d;

    logic             in_range;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             commit;
    logic [IDX_W-1:0] c_idx;
    logic             c_rw;
    logic [DW-1:0]    c_wdata;
    logic             mem_we;

    assign in_range = ({1'b0, addr} < DEPTH_C);

    slave_wait_counter u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load),
        .value (WAIT_LOAD),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        commit   = 1'b0;
        // Commit uses the captured access unless it completes straight from
        // the sample cycle (zero wait states), where the live inputs apply.
        c_idx    = idx_q;
        c_rw     = rw_q;
        c_wdata  = wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sel) begin
                    idx_d   = addr[IDX_W-1:0];
                    rw_d    = read_write;
                    wdata_d = wdata;
                    if (!in_range) begin
                        state_d = ST_ERR1;
                    end else if (hold) begin
                        state_d = ST_RTY1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                        c_idx   = addr[IDX_W-1:0];
                        c_rw    = read_write;
                        c_wdata = wdata;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            ST_RTY1: state_d = ST_RTY2;
            ST_RTY2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Read data is captured on the edge entering DONE; writes leave it.
        if (commit && c_rw == RW_READ) begin
            rdata_d = mem_q[c_idx];
        end

        ready_d = state_ready(state_d);
        case (state_d)
            ST_ERR1, ST_ERR2: response_d = RESP_ERROR;
            ST_RTY1, ST_RTY2: response_d = RTY_RESP;
            default:          response_d = RESP_OKAY;
        endcase
    end

    // A reset edge that coincides with a commit discards the access.
    assign mem_we = commit && (c_rw == RW_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[c_idx] <= c_wdata;
        end
    end

`ifdef SLAVE_SPLIT_EN
    logic split_q, split_d;
    logic split_pend_q, split_pend_d;

    // Pulse once when the slave frees up. A SPLIT finishing while a pulse is
    // already pending folds into that same pulse.
    always_comb begin
        split_d      = split_pend_q && !hold;
        split_pend_d = split_pend_q && hold;
        if (state_q == ST_RTY2 && !split_pend_q) begin
            split_pend_d = 1'b1;
        end
    end

    assign split = split_q;
`else
    assign split = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rw_q         <= RW_READ;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b1;
            response_q   <= RESP_OKAY;
`ifdef SLAVE_SPLIT_EN
            split_q      <= 1'b0;
            split_pend_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            response_q   <= response_d;
`ifdef SLAVE_SPLIT_EN
            split_q      <= split_d;
            split_pend_q <= split_pend_d;
`endif
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign response = response_q;

endmodule

// File: tb/tb_bus_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_responder
//   Directed, table-driven bench. u_dut uses WAIT_CYCLES=2 and runs the
//   vector table plus a reset-during-wait sequence; u_dut0 uses WAIT_CYCLES=0
//   for back-to-back accesses.
// ---------------------------------------------------------------------------
module tb_bus_slave_responder;

`ifdef SLAVE_SPLIT_EN
    localparam logic [1:0] RTY_EXP = 2'b11;
    localparam logic       SP_EXP  = 1'b1;
`else
    localparam logic [1:0] RTY_EXP = 2'b10;
    localparam logic       SP_EXP  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, rw, hold;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic        ready, split;
    logic [1:0]  resp;

    logic        sel_z, rw_z, hold_z;
    logic [7:0]  addr_z;
    logic [31:0] wdata_z, rdata_z;
    logic        ready_z, split_z;
    logic [1:0]  resp_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_slave_responder #(.AW(8), .DW(32), .DEPTH(64), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .sel(sel), .read_write(rw), .addr(addr),
        .wdata(wdata), .hold(hold), .rdata(rdata), .ready(ready),
        .response(resp), .split(split)
    );

    bus_slave_responder #(.AW(8), .DW(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .sel(sel_z), .read_write(rw_z), .addr(addr_z),
        .wdata(wdata_z), .hold(hold_z), .rdata(rdata_z), .ready(ready_z),
        .response(resp_z), .split(split_z)
    );

    typedef struct {
        logic        sel;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        hold;
        logic        ready;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        split;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic w, input logic [7:0] a,
                       input logic [31:0] wd, input logic h, input logic r,
                       input logic [1:0] rs, input logic [31:0] rd, input logic sp);
        vec_t v;
        v.sel = s; v.rw = w; v.addr = a; v.wdata = wd; v.hold = h;
        v.ready = r; v.resp = rs; v.rdata = rd; v.split = sp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic w, input logic [7:0] a,
                         input logic [31:0] wd, input logic h);
        sel = s; rw = w; addr = a; wdata = wd; hold = h;
    endtask

    task automatic drive0(input logic s, input logic w, input logic [7:0] a,
                          input logic [31:0] wd);
        sel_z = s; rw_z = w; addr_z = a; wdata_z = wd; hold_z = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Each row: inputs held for one clock, outputs expected after that edge.
        // A: write mem[5], hold toggling during WAIT has no effect
        add(1, 1, 8'd5,  32'hA5A5_0001, 0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         1,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h0, 0);
        // B: write mem[3]
        add(1, 1, 8'd3,  32'h1122_3344, 0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h0, 0);
        // C: write mem[0]
        add(1, 1, 8'd0,  32'h0BAD_0000, 0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h0, 0);
        // D: read mem[5] straight from DONE
        add(1, 0, 8'd5,  32'h0,         0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h0, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        // F: out-of-range read beats hold; sel ignored in ERR1/ERR2
        add(1, 0, 8'd64, 32'h0,         1,  0, 2'b01, 32'hA5A5_0001, 0);
        add(1, 0, 8'd5,  32'h0,         0,  1, 2'b01, 32'hA5A5_0001, 0);
        add(1, 0, 8'd5,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        // G: out-of-range write (must not alias onto mem[0])
        add(1, 1, 8'd64, 32'hFFFF_FFFF, 0,  0, 2'b01, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b01, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        // H: held write to mem[3] -> retry/split, split pulse after hold drops
        add(1, 1, 8'd3,  32'hDEAD_BEEF, 1,  0, RTY_EXP, 32'hA5A5_0001, 0);
        add(1, 1, 8'd3,  32'hDEAD_BEEF, 0,  1, RTY_EXP, 32'hA5A5_0001, 0);
        add(1, 1, 8'd3,  32'hDEAD_BEEF, 1,  1, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         1,  1, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, SP_EXP);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'hA5A5_0001, 0);
        // I: mem[3] unchanged by the held write
        add(1, 0, 8'd3,  32'h0,         0,  0, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'hA5A5_0001, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h1122_3344, 0);
        // J: mem[0] unchanged by the out-of-range write
        add(1, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h1122_3344, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h1122_3344, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h0BAD_0000, 0);
        // L: seed mem[7] for the reset-in-WAIT sequence
        add(1, 1, 8'd7,  32'h7777_7777, 0,  0, 2'b00, 32'h0BAD_0000, 0);
        add(0, 0, 8'd0,  32'h0,         0,  0, 2'b00, 32'h0BAD_0000, 0);
        add(0, 0, 8'd0,  32'h0,         0,  1, 2'b00, 32'h0BAD_0000, 0);

        rst = 1'b1;
        drive(0, 0, 8'd0, 32'h0, 0);
        drive0(0, 0, 8'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset ready",    32'(ready),  32'd1);
        chk("reset response", 32'(resp),   32'd0);
        chk("reset split",    32'(split),  32'd0);
        chk("reset rdata",    rdata,       32'h0);
        chk("reset0 ready",   32'(ready_z), 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].hold);
            tick();
            chk($sformatf("row%0d ready", i),    32'(ready), 32'(vecs[i].ready));
            chk($sformatf("row%0d response", i), 32'(resp),  32'(vecs[i].resp));
            chk($sformatf("row%0d rdata", i),    rdata,      vecs[i].rdata);
            chk($sformatf("row%0d split", i),    32'(split), 32'(vecs[i].split));
        end

        // Reset on the edge that would otherwise commit a write to mem[7].
        drive(1, 1, 8'd7, 32'h9999_9999, 0);
        tick();
        chk("rstwait ready w1", 32'(ready), 32'd0);
        drive(0, 0, 8'd0, 32'h0, 0);
        tick();
        chk("rstwait ready w2", 32'(ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwait ready",    32'(ready), 32'd1);
        chk("rstwait response", 32'(resp),  32'd0);
        chk("rstwait rdata",    rdata,      32'h0);
        drive(1, 0, 8'd7, 32'h0, 0);
        tick();
        chk("rstwait rd ready1", 32'(ready), 32'd0);
        drive(0, 0, 8'd0, 32'h0, 0);
        tick();
        tick();
        chk("rstwait rd ready3", 32'(ready), 32'd1);
        chk("rstwait mem7",      rdata,      32'h7777_7777);

        // Zero wait states: sel held high, one access completes per clock.
        drive0(1, 1, 8'd1, 32'h0000_1111);
        tick();
        chk("b2b wr1 ready", 32'(ready_z), 32'd1);
        chk("b2b wr1 resp",  32'(resp_z),  32'd0);
        drive0(1, 1, 8'd2, 32'h0000_2222);
        tick();
        chk("b2b wr2 ready", 32'(ready_z), 32'd1);
        chk("b2b wr2 rdata", rdata_z,      32'h0);
        drive0(1, 0, 8'd2, 32'h0);
        tick();
        chk("b2b rd2 ready", 32'(ready_z), 32'd1);
        chk("b2b rd2 rdata", rdata_z,      32'h0000_2222);
        drive0(1, 0, 8'd1, 32'h0);
        tick();
        chk("b2b rd1 rdata", rdata_z,      32'h0000_1111);
        drive0(0, 0, 8'd0, 32'h0);
        tick();
        chk("b2b idle ready", 32'(ready_z), 32'd1);
        chk("b2b idle rdata", rdata_z,      32'h0000_1111);
        chk("b2b split",      32'(split_z), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
